ifq_param: RTL and testbench

//  Parametrised instruction fetch queue; line-based front end between instruction memory and dispatch.

---
 rtl/ifq_param_if.sv | 40 ++++
 rtl/ifq_param.sv | 198 +++++++++++++++++++
 tb/tb_ifq_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifq_param_if.sv
// ifq_param_if: bundles the fetch-queue signals between the queue, instruction
// memory and dispatch.
//   master : the fetch queue (drives fetch requests and the dispatch stream)
//   slave  : the environment (memory returns lines, dispatch pops/redirects)
// Signals:
//   o_fetch_req/o_fetch_addr  line fetch request and line-aligned address
//   i_line_valid/i_line       returned line, instr k at bits [32k+31:32k]
//   i_rd_en                   dispatch pops the current instruction
//   i_redirect/_addr          branch/jump redirect and 4-byte aligned target
//   o_valid/o_instr/o_pc      current instruction and its PC
//   o_abort                   pulse: in-flight fetch cancelled by a redirect
//   o_count                   occupied line slots
interface ifq_param_if #(
    parameter int LINE_INSTRS = 4,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 32
);
    logic                      o_fetch_req;
    logic [ADDR_W-1:0]         o_fetch_addr;
    logic                      i_line_valid;
    logic [32*LINE_INSTRS-1:0] i_line;
    logic                      i_rd_en;
    logic                      i_redirect;
    logic [ADDR_W-1:0]         i_redirect_addr;
    logic                      o_valid;
    logic [31:0]               o_instr;
    logic [ADDR_W-1:0]         o_pc;
    logic                      o_abort;
    logic [$clog2(DEPTH):0]    o_count;

    modport master (
        output o_fetch_req, o_fetch_addr, o_valid, o_instr, o_pc, o_abort, o_count,
        input  i_line_valid, i_line, i_rd_en, i_redirect, i_redirect_addr
    );

    modport slave (
        input  o_fetch_req, o_fetch_addr, o_valid, o_instr, o_pc, o_abort, o_count,
        output i_line_valid, i_line, i_rd_en, i_redirect, i_redirect_addr
    );
endinterface

// File: rtl/ifq_param.sv
// ifq_param: parametrised line-based instruction fetch queue.
// Issues one line fetch at a time, buffers up to DEPTH lines and hands single
// instructions with their PC to dispatch. An empty queue forwards an arriving
// line in the same cycle; a redirect flushes the queue, re-steers fetch and
// discards a line that is still in flight.
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    ifq_param_if.master (fetch, line return, dispatch, redirect, status)
module ifq_param #(
    parameter int                LINE_INSTRS = 4,
    parameter int                DEPTH       = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ifq_param_if.master bus
);
    localparam int LINE_W     = 32 * LINE_INSTRS;
    localparam int LINE_BYTES = 4 * LINE_INSTRS;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int SLOT_W     = $clog2(LINE_INSTRS);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT_C    = SLOT_W'(LINE_INSTRS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE_C     = SLOT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE_C      = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]  DEPTH_C        = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LINE_BYTES_C   = ADDR_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] INSTR_BYTES_C  = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK_C   = ~(ADDR_W'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] pc_r;
    logic [SLOT_W-1:0] slot_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              abort_r;
    logic [LINE_W-1:0] mem_r [DEPTH];

    logic              empty_s;
    logic              bypass_s;
    logic              valid_s;
    logic              write_s;
    logic              pop_s;
    logic              line_pop_s;
    logic              fetch_req_s;
    logic [LINE_W-1:0] cur_line_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] fetch_addr_s;

    // Read side, write/pop qualification and next occupancy.
    always_comb begin
        empty_s  = (count_r == {CNT_W{1'b0}});
        // Empty queue: the line on the bus is the head line for this cycle.
        bypass_s = empty_s && (state_r == ST_WAIT) && bus.i_line_valid;
        if (empty_s) begin
            cur_line_s = bus.i_line;
        end else begin
            cur_line_s = mem_r[rd_ptr_r];
        end
        valid_s      = !empty_s || bypass_s;
        // Redirect overrides any write or pop in its cycle.
        write_s      = (state_r == ST_WAIT) && bus.i_line_valid && !bus.i_redirect;
        pop_s        = bus.i_rd_en && valid_s && !bus.i_redirect;
        line_pop_s   = pop_s && (slot_r == LAST_SLOT_C);
        count_next_s = count_r + {{(CNT_W-1){1'b0}}, write_s}
                               - {{(CNT_W-1){1'b0}}, line_pop_s};
    end

    // Fetch request: IDLE asks when a slot is free; WAIT re-requests in the
    // line-return cycle if a slot is still free after the write and any pop.
    always_comb begin
        fetch_req_s  = 1'b0;
        fetch_addr_s = fetch_pc_r;
        if (i_rst || bus.i_redirect) begin
            fetch_req_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            fetch_req_s = (count_r < DEPTH_C);
        end else if (write_s) begin
            fetch_req_s  = (count_next_s < DEPTH_C);
            fetch_addr_s = fetch_pc_r + LINE_BYTES_C;
        end else begin
            fetch_req_s = 1'b0;
        end
    end

    assign bus.o_fetch_req  = fetch_req_s;
    assign bus.o_fetch_addr = fetch_addr_s;
    assign bus.o_valid      = valid_s;
    assign bus.o_instr      = cur_line_s[{slot_r, 5'b00000} +: 32];
    assign bus.o_pc         = pc_r;
    assign bus.o_abort      = abort_r;
    assign bus.o_count      = count_r;

    // Line storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (write_s && !i_rst) begin
            mem_r[wr_ptr_r] <= bus.i_line;
        end
    end

    // Fetch FSM, queue pointers, occupancy, PC/slot and abort pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            pc_r       <= RESET_PC;
            slot_r     <= {SLOT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            abort_r    <= 1'b0;
        end else if (bus.i_redirect) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            fetch_pc_r <= bus.i_redirect_addr & ALIGN_MASK_C;
            slot_r     <= bus.i_redirect_addr[OFF_W-1:2];
            pc_r       <= bus.i_redirect_addr;
            case (state_r)
                ST_WAIT: begin
                    // A line returning this very cycle is simply not written;
                    // otherwise it is still owed and must be swallowed later.
                    if (bus.i_line_valid) begin
                        state_r <= ST_IDLE;
                        abort_r <= 1'b0;
                    end else begin
                        state_r <= ST_DROP;
                        abort_r <= 1'b1;
                    end
                end
                ST_DROP: begin
                    // The owed line arriving in the redirect cycle is consumed
                    // here, so nothing remains to drop.
                    if (bus.i_line_valid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                    abort_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    abort_r <= 1'b0;
                end
            endcase
        end else begin
            abort_r <= 1'b0;
            count_r <= count_next_s;
            if (write_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_ONE_C;
                fetch_pc_r <= fetch_pc_r + LINE_BYTES_C;
            end
            if (pop_s) begin
                pc_r <= pc_r + INSTR_BYTES_C;
                // Last instruction of the head line releases the line; the
                // next line always starts at slot 0.
                if (line_pop_s) begin
                    slot_r   <= {SLOT_W{1'b0}};
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end else begin
                    slot_r <= slot_r + SLOT_ONE_C;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (fetch_req_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_line_valid) begin
                        state_r <= fetch_req_s ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (bus.i_line_valid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifq_param.sv
// tb_ifq_param: randomized scoreboard bench for ifq_param.
// The bench plays instruction memory (single pending fetch, random latency)
// and dispatch. Each accepted line pushes its expected (pc, instr) stream into
// a queue; a negedge monitor pops and compares whenever the DUT pops.
module tb_ifq_param;
    localparam int          LI    = 4;
    localparam int          DEPTH = 4;
    localparam int          AW    = 32;
    localparam int          LB    = 4 * LI;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifq_param_if #(.LINE_INSTRS(LI), .DEPTH(DEPTH), .ADDR_W(AW)) bus ();

    ifq_param #(.LINE_INSTRS(LI), .DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(RPC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          passes = 0;
    exp_t        exp_q[$];
    int          lines_m = 0;
    logic [31:0] exp_fetch = RPC;
    int          start_slot = 0;
    bit          pend_v = 1'b0;
    bit          pend_stale = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_ready = 0;
    int          cyc = 0;
    bit          abort_exp = 1'b0;
    int          nreq = 0;
    logic [31:0] last_req_addr = 32'h0;
    bit          running = 1'b0;
    // stimulus knobs
    int          rd_pct = 0;
    int          redir_pct = 0;
    int          ret_pct = 100;
    int          lat_max = 1;
    bit          force_redir = 1'b0;
    bit          force_with_line = 1'b0;
    logic [31:0] force_addr = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [32*LI-1:0] make_line(input logic [31:0] a);
        logic [32*LI-1:0] l;
        for (int k = 0; k < LI; k++) l[32*k +: 32] = instr_of(a + 32'(4 * k));
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One stimulus cycle: check registered state, then drive memory/dispatch.
    task automatic step();
        bit          line_now;
        bit          redir;
        logic [31:0] tgt;
        exp_t        e;
        @(posedge clk); #1;
        cyc++;
        check("count", 64'(bus.o_count), 64'(lines_m));
        check("abort", 64'(bus.o_abort), 64'(abort_exp));
        abort_exp = 1'b0;
        line_now = pend_v && (cyc >= pend_ready) && ($urandom_range(99) < ret_pct);
        bus.i_line_valid = line_now;
        bus.i_line = line_now ? make_line(pend_addr) : {$urandom, $urandom, $urandom, $urandom};
        bus.i_rd_en = ($urandom_range(99) < rd_pct);
        redir = 1'b0;
        tgt = 32'h0;
        if (force_redir) begin
            if (force_with_line ? (line_now && !pend_stale) : (pend_v && !pend_stale && !line_now)) begin
                redir = 1'b1;
                tgt = force_addr;
                force_redir = 1'b0;
                if (force_with_line) bus.i_rd_en = 1'b1;
            end
        end else if (!(pend_stale && line_now) && ($urandom_range(99) < redir_pct)) begin
            redir = 1'b1;
            tgt = $urandom & 32'h0000_3FFC;
        end
        bus.i_redirect = redir;
        bus.i_redirect_addr = tgt;
        if (redir) begin
            abort_exp = pend_v && !pend_stale && !line_now;
            if (pend_v && line_now) pend_v = 1'b0;
            else if (pend_v) pend_stale = 1'b1;
            exp_q.delete();
            lines_m = 0;
            exp_fetch = tgt & ~(32'(LB - 1));
            start_slot = int'((tgt & 32'(LB - 1)) >> 2);
        end else if (line_now) begin
            pend_v = 1'b0;
            if (!pend_stale) begin
                for (int k = start_slot; k < LI; k++) begin
                    e.pc = pend_addr + 32'(4 * k);
                    e.instr = instr_of(e.pc);
                    e.last = (k == LI - 1);
                    exp_q.push_back(e);
                end
                lines_m++;
                start_slot = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_line_valid = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_redirect_addr = 32'h0;
        bus.i_line = '0;
        pend_v = 1'b0;
        pend_stale = 1'b0;
        exp_q.delete();
        lines_m = 0;
        exp_fetch = RPC;
        start_slot = 0;
        abort_exp = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_count", 64'(bus.o_count), 64'd0);
        check("rst_pc", 64'(bus.o_pc), 64'(RPC));
        check("rst_abort", 64'(bus.o_abort), 64'd0);
        rst = 1'b0;
        running = 1'b1;
    endtask

    // Monitor: dispatch pops against the scoreboard; memory accepts requests.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (running) check("req_in_rst", 64'(bus.o_fetch_req), 64'd0);
        end else if (running) begin
            if (!bus.i_redirect) begin
                check("valid", 64'(bus.o_valid), 64'(exp_q.size() != 0));
                if (bus.o_valid && bus.i_rd_en && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pc", 64'(bus.o_pc), 64'(e.pc));
                    check("instr", 64'(bus.o_instr), 64'(e.instr));
                    if (e.last) lines_m--;
                end
            end
            if (bus.o_fetch_req) begin
                check("req_addr", 64'(bus.o_fetch_addr), 64'(exp_fetch));
                check("req_single", 64'(pend_v), 64'd0);
                check("req_room", 64'(lines_m < DEPTH), 64'd1);
                check("req_no_redir", 64'(bus.i_redirect), 64'd0);
                pend_v = 1'b1;
                pend_stale = 1'b0;
                pend_addr = bus.o_fetch_addr;
                pend_ready = cyc + 1 + int'($urandom_range(lat_max - 1));
                exp_fetch = exp_fetch + 32'(LB);
                last_req_addr = bus.o_fetch_addr;
                nreq++;
            end
        end
    end

    task automatic forced(input logic [31:0] a, input bit with_line);
        force_addr = a;
        force_with_line = with_line;
        force_redir = 1'b1;
        for (int i = 0; i < 200 && force_redir; i++) step();
        if (force_redir) begin
            checks++;
            $display("FAIL forced_redirect: got no opportunity expected redirect to %0h", a);
            force_redir = 1'b0;
        end
        for (int i = 0; i < 30; i++) step();
    endtask

    initial begin
        bus.i_line_valid = 1'b0;
        bus.i_line = '0;
        bus.i_rd_en = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_redirect_addr = 32'h0;
        do_reset();

        // Fill with 1-cycle memory and no pops: four requests, then full.
        rd_pct = 0; ret_pct = 100; lat_max = 1;
        for (int i = 0; i < 20; i++) step();
        check("fill_reqs", 64'(nreq), 64'd4);
        // Pop one full line; the refill request appears when count drops to 3.
        rd_pct = 100;
        for (int i = 0; i < 4; i++) step();
        rd_pct = 0;
        step();
        #5;
        check("refill_reqs", 64'(nreq), 64'd5);
        check("refill_addr", 64'(last_req_addr), 64'h40);

        // Bypass from empty after reset, draining continuously.
        do_reset();
        rd_pct = 100;
        for (int i = 0; i < 24; i++) step();

        // Redirect while waiting: abort, drop, mid-line entry.
        rd_pct = 50; ret_pct = 60; lat_max = 3;
        forced(32'h0000_0108, 1'b0);
        // Redirect coinciding with a returning line and a pop.
        forced(32'h0000_0204, 1'b1);
        // Address wrap past the top of the address space.
        forced(32'hFFFF_FFF8, 1'b0);

        // Reset with three lines queued.
        rd_pct = 0; ret_pct = 100; lat_max = 2;
        do_reset();
        for (int i = 0; i < 50 && lines_m < 3; i++) step();
        check("three_lines", 64'(lines_m), 64'd3);
        do_reset();
        for (int i = 0; i < 10; i++) step();

        // Random traffic.
        rd_pct = 60; redir_pct = 3; ret_pct = 60; lat_max = 3;
        for (int i = 0; i < 3000; i++) step();
        redir_pct = 0;
        for (int i = 0; i < 20; i++) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
